// File: rtl/pump_pkg.sv
// Shared encodings and limits for the pump timer, its command front end
// and the LCD page.
package pump_pkg;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_SET_PERIOD = 2'd1,
        S_SET_ON     = 2'd2,
        S_SET_PUMP   = 2'd3
    } menu_state_e;

    localparam logic [1:0] PUMP_A  = 2'b01;
    localparam logic [1:0] PUMP_B  = 2'b10;
    localparam logic [1:0] PUMP_AB = 2'b11;

    localparam int DEF_PERIOD   = 60;
    localparam int MAX_PERIOD   = 3600;
    localparam int MIN_PERIOD   = 2;
    localparam int DEF_ON       = 5;
    localparam int MAX_ON       = 600;
    localparam int MIN_ON       = 1;
    localparam int DEF_HUM_LOW  = 30;
    localparam int DEF_HUM_HIGH = 40;

    function automatic int stable_cycles(int freq, int ms);
        return freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/pump_cmd_controller_btn_debounce.sv
// Button synchroniser plus stability counter; emits a 1-clk pulse on an
// accepted rising level only.
module btn_debounce
    import pump_pkg::*;
#(
    parameter int CLOCK_FREQ  = 1_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int N  = stable_cycles(CLOCK_FREQ, DEBOUNCE_MS);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    // two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // accept a new level once it has held for N cycles; any bounce restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(N - 1)) begin
                stable <= s2;
                cnt    <= '0;
                press  <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pump_cmd_controller.sv
// Menu FSM, config registers and command pulse arbiter for the pump timer.
// Define HUMIDITY_AUTO_EN to enable auto-watering from humidity samples.
module pump_cmd_controller
    import pump_pkg::*;
#(
    parameter int CLOCK_FREQ  = 1_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int PERIOD_DEF  = DEF_PERIOD,
    parameter int PERIOD_MAX  = MAX_PERIOD,
    parameter int ON_DEF      = DEF_ON,
    parameter int ON_MAX      = MAX_ON,
    parameter int HUM_LOW     = DEF_HUM_LOW,
    parameter int HUM_HIGH    = DEF_HUM_HIGH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_force,
    input  logic [7:0]  humidity,
    input  logic        humidity_valid,
    output logic [1:0]  pump_select,
    output logic [31:0] period_seconds,
    output logic [31:0] pulse_on_time,
    output logic        timer_start,
    output logic        force_pulse,
    output logic [1:0]  menu_state,
    output logic        cfg_changed
);

    logic mode_p, up_p, dn_p, force_p;

    btn_debounce #(.CLOCK_FREQ(CLOCK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS))
        u_db_mode  (.clk(clk), .rst_n(rst_n), .btn_raw(btn_mode),  .press(mode_p));
    btn_debounce #(.CLOCK_FREQ(CLOCK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS))
        u_db_up    (.clk(clk), .rst_n(rst_n), .btn_raw(btn_up),    .press(up_p));
    btn_debounce #(.CLOCK_FREQ(CLOCK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS))
        u_db_down  (.clk(clk), .rst_n(rst_n), .btn_raw(btn_down),  .press(dn_p));
    btn_debounce #(.CLOCK_FREQ(CLOCK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS))
        u_db_force (.clk(clk), .rst_n(rst_n), .btn_raw(btn_force), .press(force_p));

    menu_state_e state, state_nxt;
    logic [1:0]  pump_nxt;
    logic [31:0] per_nxt, on_nxt;
    logic        pend_s, pend_f, pend_s_nxt, pend_f_nxt;
    logic        ts_nxt, fp_nxt, chg_nxt;
    logic        start_req, force_req, edit_up, edit_dn;
    logic        boot0, boot1, boot_fire, auto_fire;

    assign menu_state = state;
    assign boot_fire  = boot0 & ~boot1;
    assign edit_up    = up_p & ~dn_p;
    assign edit_dn    = dn_p & ~up_p;

`ifdef HUMIDITY_AUTO_EN
    logic armed;

    assign auto_fire = humidity_valid && (humidity < 8'(HUM_LOW))
                       && armed && (state == S_RUN);

    // hysteresis: fire once below HUM_LOW, re-arm at or above HUM_HIGH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b1;
        end else if (auto_fire) begin
            armed <= 1'b0;
        end else if (humidity_valid && (humidity >= 8'(HUM_HIGH))) begin
            armed <= 1'b1;
        end
    end
`else
    logic unused_hum;

    assign auto_fire  = 1'b0;
    assign unused_hum = ^{humidity, humidity_valid, 8'(HUM_LOW), 8'(HUM_HIGH)};
`endif

    // next state, field edits, command requests and the start-first arbiter
    always_comb begin
        state_nxt = state;
        pump_nxt  = pump_select;
        per_nxt   = period_seconds;
        on_nxt    = pulse_on_time;
        start_req = boot_fire;
        force_req = auto_fire;
        unique case (state)
            S_RUN: begin
                if (mode_p) state_nxt = S_SET_PERIOD;
                if (force_p) force_req = 1'b1;
            end
            S_SET_PERIOD: begin
                if (mode_p) state_nxt = S_SET_ON;
                if (edit_up && period_seconds < 32'(PERIOD_MAX)) begin
                    per_nxt = period_seconds + 32'd1;
                end else if (edit_dn && period_seconds > 32'd2) begin
                    per_nxt = period_seconds - 32'd1;
                    if (pulse_on_time > period_seconds - 32'd2)
                        on_nxt = period_seconds - 32'd2;
                end
            end
            S_SET_ON: begin
                if (mode_p) state_nxt = S_SET_PUMP;
                if (edit_up && pulse_on_time < period_seconds - 32'd1
                    && pulse_on_time < 32'(ON_MAX)) begin
                    on_nxt = pulse_on_time + 32'd1;
                end else if (edit_dn && pulse_on_time > 32'd1) begin
                    on_nxt = pulse_on_time - 32'd1;
                end
            end
            S_SET_PUMP: begin
                if (edit_up) begin
                    if (pump_select == PUMP_A) pump_nxt = PUMP_B;
                    else if (pump_select == PUMP_B) pump_nxt = PUMP_AB;
                end else if (edit_dn) begin
                    if (pump_select == PUMP_AB) pump_nxt = PUMP_B;
                    else if (pump_select == PUMP_B) pump_nxt = PUMP_A;
                end
                if (mode_p) begin
                    state_nxt = S_RUN;
                    start_req = 1'b1;
                    if (force_p) force_req = 1'b1;
                end
            end
            default: state_nxt = S_RUN;
        endcase
        ts_nxt     = pend_s | start_req;
        fp_nxt     = ~ts_nxt & (pend_f | force_req);
        pend_s_nxt = 1'b0;
        pend_f_nxt = ts_nxt & (pend_f | force_req);
        chg_nxt    = (state_nxt != state) || (pump_nxt != pump_select)
                     || (per_nxt != period_seconds)
                     || (on_nxt != pulse_on_time);
    end

    // state, config and command registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_RUN;
            pump_select    <= PUMP_A;
            period_seconds <= 32'(PERIOD_DEF);
            pulse_on_time  <= 32'(ON_DEF);
            pend_s         <= 1'b0;
            pend_f         <= 1'b0;
            timer_start    <= 1'b0;
            force_pulse    <= 1'b0;
            cfg_changed    <= 1'b0;
            boot0          <= 1'b0;
            boot1          <= 1'b0;
        end else begin
            state          <= state_nxt;
            pump_select    <= pump_nxt;
            period_seconds <= per_nxt;
            pulse_on_time  <= on_nxt;
            pend_s         <= pend_s_nxt;
            pend_f         <= pend_f_nxt;
            timer_start    <= ts_nxt;
            force_pulse    <= fp_nxt;
            cfg_changed    <= chg_nxt;
            boot0          <= 1'b1;
            boot1          <= boot0;
        end
    end

endmodule

// File: tb/tb_pump_cmd_controller.sv
// Scoreboard bench for pump_cmd_controller with a behavioural menu model.
// Uses a 100-cycle stable time to keep the run short.
module tb_pump_cmd_controller;

    localparam int CF     = 100_000;
    localparam int DMS    = 1;
    localparam int STABLE = CF / 1000 * DMS;
    localparam int HOLD   = STABLE + 20;
    localparam int PMAX   = 3600;
    localparam int OMAX   = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_mode = 1'b0, btn_up = 1'b0;
    logic        btn_down = 1'b0, btn_force = 1'b0;
    logic [7:0]  humidity = 8'd0;
    logic        humidity_valid = 1'b0;
    logic [1:0]  pump_select, menu_state;
    logic [31:0] period_seconds, pulse_on_time;
    logic        timer_start, force_pulse, cfg_changed;

    pump_cmd_controller #(.CLOCK_FREQ(CF), .DEBOUNCE_MS(DMS)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_up(btn_up),
        .btn_down(btn_down), .btn_force(btn_force),
        .humidity(humidity), .humidity_valid(humidity_valid),
        .pump_select(pump_select), .period_seconds(period_seconds),
        .pulse_on_time(pulse_on_time), .timer_start(timer_start),
        .force_pulse(force_pulse), .menu_state(menu_state),
        .cfg_changed(cfg_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int per;
        int on;
        int pump;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0, miscompares = 0;
    int  cyc = 0, last_ts = -1, last_fp = -1, n_ts = 0, n_fp = 0;
    int  got_cfg = 0, exp_cfg = 0;
    int  m_state, m_per, m_on, m_pump;
    bit  m_armed;

    task automatic chk(string n, int got, int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (cfg_changed) got_cfg++;
            if (timer_start || force_pulse) begin
                chk("cmd_overlap", int'(timer_start & force_pulse), 0);
                chk("cmd_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("cmd_kind", force_pulse ? 1 : 0, e.kind);
                    chk("cmd_period", int'(period_seconds), e.per);
                    chk("cmd_on", int'(pulse_on_time), e.on);
                    chk("cmd_pump", int'(pump_select), e.pump);
                end
                if (timer_start) begin
                    last_ts = cyc;
                    n_ts++;
                end else begin
                    last_fp = cyc;
                    n_fp++;
                end
            end
        end
    end

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic push_ev(int k);
        ev_t e;
        e.kind = k;
        e.per  = m_per;
        e.on   = m_on;
        e.pump = m_pump;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_per   = 60;
        m_on    = 5;
        m_pump  = 1;
        m_armed = 1'b1;
    endtask

    task automatic model_press(bit mo, bit u, bit d, bit f);
        int  step, os, op, oo, opu;
        bit  fs, ff;
        os = m_state; op = m_per; oo = m_on; opu = m_pump;
        step = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
        case (m_state)
            1: begin
                m_per = clampi(m_per + step, 2, PMAX);
                m_on  = clampi(m_on, 1, m_per - 1);
            end
            2: m_on = clampi(m_on + step, 1, (OMAX < m_per - 1) ? OMAX : m_per - 1);
            3: m_pump = clampi(m_pump + step, 1, 3);
            default: ;
        endcase
        fs = mo && (m_state == 3);
        ff = f && ((m_state == 0) || fs);
        if (mo) m_state = (m_state + 1) % 4;
        if (os != m_state || op != m_per || oo != m_on || opu != m_pump)
            exp_cfg++;
        if (fs) push_ev(0);
        if (ff) push_ev(1);
    endtask

    task automatic press(bit mo, bit u, bit d, bit f);
        model_press(mo, u, d, f);
        @(negedge clk);
        btn_mode = mo; btn_up = u; btn_down = d; btn_force = f;
        repeat (HOLD) @(negedge clk);
        btn_mode = 0; btn_up = 0; btn_down = 0; btn_force = 0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic check_outputs(string tag);
        chk({tag, "_state"}, int'(menu_state), m_state);
        chk({tag, "_pump"}, int'(pump_select), m_pump);
        chk({tag, "_period"}, int'(period_seconds), m_per);
        chk({tag, "_on"}, int'(pulse_on_time), m_on);
    endtask

    task automatic hum_sample(int v);
`ifdef HUMIDITY_AUTO_EN
        if (v < 30 && m_armed && m_state == 0) begin
            push_ev(1);
            m_armed = 1'b0;
        end else if (v >= 40) begin
            m_armed = 1'b1;
        end
`endif
        @(negedge clk);
        humidity = 8'(v);
        humidity_valid = 1'b1;
        @(negedge clk);
        humidity_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        push_ev(0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int ts0, fp0, t_edge, d;
        int exp_pump[5];
        int hum_v[6];
        bit mo, u, dn, f;
        int r;
        exp_pump = '{2, 3, 3, 3, 3};
        hum_v    = '{35, 25, 20, 38, 45, 25};

        // 1: reset and boot start
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        chk("reset_ts", int'(timer_start), 0);
        chk("reset_fp", int'(force_pulse), 0);
        push_ev(0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("boot_ts_cycle", last_ts, 2);
        chk("boot_ts_count", n_ts, 1);
        chk("boot_fp_count", n_fp, 0);
        check_outputs("boot");

        // 2: bouncing force button
        fp0 = n_fp;
        model_press(0, 0, 0, 1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            btn_force = ~btn_force;
            repeat (STABLE / 10) @(negedge clk);
        end
        btn_force = 1'b1;
        t_edge = cyc;
        repeat (HOLD + STABLE / 2) @(negedge clk);
        btn_force = 1'b0;
        repeat (HOLD) @(negedge clk);
        chk("bounce_fp_count", n_fp - fp0, 1);
        d = last_fp - t_edge;
        chk("bounce_latency_ok", int'(d >= STABLE && d <= STABLE + 5), 1);

        // 3: period down to the floor drags on-time along
        press(1, 0, 0, 0);
        for (int i = 0; i < 59; i++) press(0, 0, 1, 0);
        chk("floor_period", int'(period_seconds), 2);
        chk("floor_on", int'(pulse_on_time), 1);
        ts0 = n_ts;
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        chk("exit_state", int'(menu_state), 0);
        chk("exit_ts_count", n_ts - ts0, 1);
        chk("cfg_count_t3", got_cfg, exp_cfg);
        check_outputs("t3");

        // 4: pump selection saturates; force ignored in a set state
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            press(0, 1, 0, 0);
            chk("pump_step", int'(pump_select), exp_pump[i]);
        end
        fp0 = n_fp;
        press(0, 0, 0, 1);
        chk("setstate_force", n_fp - fp0, 0);

        // 5: exit and force together
        ts0 = n_ts;
        fp0 = n_fp;
        press(1, 0, 0, 1);
        chk("both_ts_count", n_ts - ts0, 1);
        chk("both_fp_count", n_fp - fp0, 1);
        chk("both_order", last_fp - last_ts, 1);
        check_outputs("t5");

        // 6: humidity auto trigger with hysteresis
        fp0 = n_fp;
        for (int i = 0; i < 6; i++) hum_sample(hum_v[i]);
`ifdef HUMIDITY_AUTO_EN
        chk("hum_fp_count", n_fp - fp0, 2);
`else
        chk("hum_fp_count", n_fp - fp0, 0);
`endif

        // random menu traffic
        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            mo = (r <= 2);
            u  = (r >= 3 && r <= 5) || r == 9;
            dn = (r >= 6);
            f  = ($urandom_range(0, 3) == 0);
            press(mo, u, dn, f);
            check_outputs("rand");
        end

        // reset in the middle of an edit discards it
        if (m_state == 0) press(1, 0, 0, 0);
        if (m_state == 0) press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        ts0 = n_ts;
        do_reset();
        check_outputs("midreset");
        chk("midreset_ts_cycle", last_ts, 2);
        chk("midreset_ts_count", n_ts - ts0, 1);

        chk("queue_drained", exp_q.size(), 0);
        chk("cfg_count_final", got_cfg, exp_cfg);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
